// File: rtl/rdata3_pixel_unpacker.sv
// +----------------------------------------------------------------------------+
// | rdata3_pixel_unpacker                                                      |
// | Unpacks channel-3 read-FIFO words into a framed RGB565 valid/ready stream. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rdata3_pixel_unpacker #(
    parameter int c_RD_DATA_WIDTH = 32,
    parameter int c_PIX_WIDTH     = 16,
    parameter int c_H_ACTIVE      = 1920,
    parameter int c_V_ACTIVE      = 1080,
    parameter int c_CNT_WIDTH     = 12
) (
    input  logic                       rd_clk,
    input  logic                       rd_rst_n,
    input  logic                       frame_start,
    output logic                       fifo_rd_en,
    input  logic [c_RD_DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                       fifo_rd_empty,
    output logic [c_PIX_WIDTH-1:0]     m_pix_data,
    output logic                       m_pix_valid,
    input  logic                       m_pix_ready,
    output logic                       m_pix_sof,
    output logic                       m_pix_eol,
    output logic                       m_pix_eof,
    output logic                       busy,
    output logic                       err_restart
);

    localparam int c_FRAME_WORDS = c_H_ACTIVE * c_V_ACTIVE / 2;
    localparam int c_WL_WIDTH    = $clog2(c_FRAME_WORDS + 1);
    localparam logic [c_CNT_WIDTH-1:0] c_X_LAST = c_CNT_WIDTH'(c_H_ACTIVE - 1);
    localparam logic [c_CNT_WIDTH-1:0] c_Y_LAST = c_CNT_WIDTH'(c_V_ACTIVE - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                     r_state;
    logic [c_WL_WIDTH-1:0]      r_words_left;
    logic [c_RD_DATA_WIDTH-1:0] r_buf [2];
    logic [1:0]                 r_buf_count;
    logic                       r_wr_ptr;
    logic                       r_rd_ptr;
    logic                       r_half;
    logic                       r_inflight;
    logic [c_CNT_WIDTH-1:0]     r_x;
    logic [c_CNT_WIDTH-1:0]     r_y;

    logic                       w_run;
    logic [c_RD_DATA_WIDTH-1:0] w_head;
    logic [c_PIX_WIDTH-1:0]     w_pix_next;
    logic                       w_pix_avail;
    logic                       w_accept;
    logic                       w_load;
    logic                       w_pop;
    logic                       w_last;
    logic [c_CNT_WIDTH-1:0]     w_x_adv;
    logic [c_CNT_WIDTH-1:0]     w_y_adv;
    logic [c_CNT_WIDTH-1:0]     w_x_ld;
    logic [c_CNT_WIDTH-1:0]     w_y_ld;

    assign w_run      = (r_state == ST_RUN);
    assign fifo_rd_en = w_run & ~fifo_rd_empty & (r_words_left != '0)
                      & ((r_buf_count + {1'b0, r_inflight}) < 2'd2);

    // With the buffer empty the word arriving from the FIFO is used directly,
    // which gives the first pixel three cycles after frame_start.
    assign w_head      = (r_buf_count != 2'd0) ? r_buf[r_rd_ptr] : fifo_rd_data;
    assign w_pix_avail = w_run & ((r_buf_count != 2'd0) | r_inflight);
    assign w_pix_next  = r_half ? w_head[2*c_PIX_WIDTH-1:c_PIX_WIDTH]
                                : w_head[c_PIX_WIDTH-1:0];

    assign w_accept = m_pix_valid & m_pix_ready;
    assign w_load   = w_pix_avail & (~m_pix_valid | m_pix_ready);
    assign w_pop    = w_load & r_half;
    assign w_last   = w_accept & m_pix_eof;

    // x/y name the oldest pixel not yet accepted; the pixel being loaded sits
    // one position further on when the current one is accepted in this cycle.
    always_comb begin
        w_x_adv = r_x + c_CNT_WIDTH'(1);
        w_y_adv = r_y;
        if (r_x == c_X_LAST) begin
            w_x_adv = '0;
            w_y_adv = (r_y == c_Y_LAST) ? '0 : r_y + c_CNT_WIDTH'(1);
        end
        w_x_ld = w_accept ? w_x_adv : r_x;
        w_y_ld = w_accept ? w_y_adv : r_y;
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            r_state      <= ST_IDLE;
            r_words_left <= '0;
            r_buf[0]     <= '0;
            r_buf[1]     <= '0;
            r_buf_count  <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_half       <= 1'b0;
            r_inflight   <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            m_pix_data   <= '0;
            m_pix_valid  <= 1'b0;
            m_pix_sof    <= 1'b0;
            m_pix_eol    <= 1'b0;
            m_pix_eof    <= 1'b0;
            busy         <= 1'b0;
            err_restart  <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (fifo_rd_en) begin
                r_words_left <= r_words_left - c_WL_WIDTH'(1);
            end
            if (r_inflight) begin
                r_buf[r_wr_ptr] <= fifo_rd_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_load) begin
                r_half <= ~r_half;
            end
            r_buf_count <= r_buf_count + {1'b0, r_inflight} - {1'b0, w_pop};

            if (w_accept) begin
                r_x <= w_x_adv;
                r_y <= w_y_adv;
            end

            if (w_load) begin
                m_pix_valid <= 1'b1;
                m_pix_data  <= w_pix_next;
                m_pix_sof   <= (w_x_ld == '0) && (w_y_ld == '0);
                m_pix_eol   <= (w_x_ld == c_X_LAST);
                m_pix_eof   <= (w_x_ld == c_X_LAST) && (w_y_ld == c_Y_LAST);
            end else if (w_accept) begin
                m_pix_valid <= 1'b0;
                m_pix_sof   <= 1'b0;
                m_pix_eol   <= 1'b0;
                m_pix_eof   <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_state      <= ST_RUN;
                        busy         <= 1'b1;
                        r_words_left <= c_WL_WIDTH'(c_FRAME_WORDS);
                        r_x          <= '0;
                        r_y          <= '0;
                    end
                end
                ST_RUN: begin
                    if (frame_start) begin
                        err_restart <= 1'b1;
                    end
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/rdata3_pixel_unpacker.md
# rdata3_pixel_unpacker

Read-side consumer for the channel-3 read-data FIFO in the video path. Pops 32-bit words from the FIFO (non-registered output, one-cycle read latency), buffers up to two words, splits each into two 16-bit RGB565 pixels and presents them as a valid/ready pixel stream. The stream carries line/frame framing markers for the downstream display/scaler stage. Everything runs in the FIFO read-clock domain.

## Interface
- c_RD_DATA_WIDTH, 32, FIFO word width; must equal 2*c_PIX_WIDTH
- c_PIX_WIDTH, 16, pixel width
- c_H_ACTIVE, 1920, pixels per line; even, at least 2
- c_V_ACTIVE, 1080, lines per frame; at least 1
- c_CNT_WIDTH, 12, width of the x/y counters; 2^c_CNT_WIDTH > max(c_H_ACTIVE, c_V_ACTIVE)

Ports:
- rd_clk  in  1  read clock, sole clock
- rd_rst_n  in  1  reset, synchronous, active-low
- frame_start  in  1  one-cycle pulse that arms one frame
- fifo_rd_en  out  1  FIFO read enable
- fifo_rd_data  in  c_RD_DATA_WIDTH  FIFO read data; valid in the cycle after a read
- fifo_rd_empty  in  1  FIFO empty flag
- m_pix_data  out  c_PIX_WIDTH  pixel
- m_pix_valid  out  1  pixel valid
- m_pix_ready  in  1  downstream ready
- m_pix_sof  out  1  first pixel of the frame
- m_pix_eol  out  1  last pixel of a line
- m_pix_eof  out  1  last pixel of the frame
- busy  out  1  high while in RUN
- err_restart  out  1  sticky; set when frame_start arrives while in RUN

## Operation
- Reset (rd_rst_n=0 at a rising edge) puts the block in this state:
  - state IDLE
  - all outputs 0
  - buffer, in-flight flag and counters cleared
  - err_restart cleared
- States:
  - IDLE: frame_start=1 -> RUN. Loads words_left = c_H_ACTIVE*c_V_ACTIVE/2 and clears x and y.
  - RUN: stays until the last pixel of the frame is accepted (m_pix_valid & m_pix_ready & m_pix_eof), then -> IDLE.
  - frame_start in RUN: ignored, except that it sets err_restart.
- FIFO read:
  - fifo_rd_en = RUN & !fifo_rd_empty & words_left!=0 & (buf_count + inflight) < 2.
  - fifo_rd_en is combinational from registered state and fifo_rd_empty. It is never high when fifo_rd_empty=1.
  - Each read decrements words_left and sets inflight for one cycle.
  - The next cycle captures fifo_rd_data into the 2-entry word buffer.
- Unpack order:
  - bits [c_PIX_WIDTH-1:0] first, upper half second.
  - A word leaves the buffer after its second pixel loads into the output register.
- Output register:
  - loads when (!m_pix_valid | m_pix_ready) and a pixel is available; otherwise holds.
  - m_pix_valid, m_pix_data and the markers are stable while valid=1 and ready=0.
  - with no pixel available, valid drops after acceptance.
- Counters advance on acceptance:
  - x wraps at c_H_ACTIVE-1 to 0 and increments y.
  - m_pix_sof = (x==0 & y==0).
  - m_pix_eol = (x==c_H_ACTIVE-1).
  - m_pix_eof = eol & (y==c_V_ACTIVE-1).
  - markers are registered together with the pixel they qualify.
- FIFO empty mid-frame: no error. The stream stalls (valid=0) and resumes when data arrives.
- Pixels beyond the frame count are never read; FIFO contents past the frame stay in the FIFO.
- Reset mid-frame: everything is discarded immediately and the block returns to IDLE. Flushing the upstream FIFO is the owner's responsibility.

## Timing
- frame_start in cycle N:
  - busy=1 from N+1
  - fifo_rd_en may assert in N+1
  - word captured at the end of N+2
  - first m_pix_valid=1 in N+3
- Steady state, ready=1 and FIFO never empty: one pixel per cycle, no bubbles. One read per two cycles; the 2-word buffer covers read latency.
- Back-pressure: ready=0 for any length loses no pixels. Reads stop once buffer plus in-flight reaches 2.
- Last pixel accepted in cycle M: busy=0 and m_pix_valid=0 in M+1. A frame_start in M+1 is accepted.
- A frame_start coincident with last-pixel acceptance is an error: err_restart sets and the block goes to IDLE.

## Test plan
- Parameters for all scenarios: c_H_ACTIVE=4, c_V_ACTIVE=2.
- Basic frame: FIFO preloaded with 0x00020001, 0x00040003, 0x00060005, 0x00080007, ready=1.
  - Pixels 1..8 on consecutive cycles.
  - sof on pixel 1, eol on pixels 4 and 8, eof on pixel 8.
  - Exactly 4 fifo_rd_en pulses.
  - busy falls the cycle after pixel 8.
- Back-pressure: same data, ready toggling 1/0 every cycle, then ready=0 for 10 cycles.
  - Same 8 pixels in order, none duplicated.
  - Data stable while stalled.
  - fifo_rd_en never high with buffer plus in-flight = 2.
- Starvation: FIFO empty for 20 cycles after frame_start, then words written one every 5 cycles.
  - valid=0 while starved.
  - fifo_rd_en=0 whenever empty.
  - Output identical to the basic frame.
- Over-length FIFO: 6 words present.
  - Exactly 4 reads.
  - FIFO left with 2 words.
  - A second frame_start outputs words 5–6 then stalls.
- Restart error: frame_start pulse mid-frame -> err_restart=1 and stays set; the frame still completes normally.
- Reset mid-frame: rd_rst_n=0 for one cycle after pixel 3 -> next cycle valid=0, busy=0, err_restart=0, no further fifo_rd_en.
